// File: rtl/cci_wr_issuer_pkg.sv
// Shared types and default sizing for the CCI-P channel-1 write issuer.
package cci_wr_issuer_pkg;

  localparam int CL_ADDR_W = 42;
  localparam int CL_DATA_W = 512;

  localparam int FIFO_DEPTH_DEF      = 8;
  localparam int SKID_MARGIN_DEF     = 3;
  localparam int MAX_OUTSTANDING_DEF = 64;
  localparam int OUTS_W_DEF          = 7;

  typedef logic [CL_ADDR_W-1:0] t_cci_clAddr;
  typedef logic [CL_DATA_W-1:0] t_cci_clData;

  typedef struct packed {
    t_cci_clAddr addr;
    t_cci_clData data;
  } t_wr_req;

endpackage

// File: rtl/cci_wr_issuer_skid_fifo.sv
// Synchronous show-ahead FIFO of write requests; a pop in the same cycle frees
// the slot so a push on a full FIFO is still accepted.
module cci_wr_issuer_skid_fifo
  import cci_wr_issuer_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  t_wr_req                  push_data,
  input  logic                     pop,
  output t_wr_req                  head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  t_wr_req        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           full;
  logic           do_push;
  logic           do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;
  assign head     = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  // Storage carries no reset; occupancy is governed by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cci_wr_issuer.sv
// Buffers the write engine's request stream and issues single-CL WrLine_I
// requests on CCI-P TX channel 1, tracking outstanding writes and quiescence.
module cci_wr_issuer
  import cci_wr_issuer_pkg::*;
#(
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF,
  parameter int SKID_MARGIN     = SKID_MARGIN_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int OUTS_W          = OUTS_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_valid,
  input  logic [41:0]       wr_addr,
  input  logic [511:0]      wr_data,
  output logic              stall,
  input  logic              c1_tx_almfull,
  output logic              c1_tx_valid,
  output logic [41:0]       c1_tx_addr,
  output logic [511:0]      c1_tx_data,
  output logic [15:0]       c1_tx_mdata,
  input  logic              c1_rx_wr_rsp,
  input  logic              cnt_clear,
  output logic [OUTS_W-1:0] outstanding,
  output logic [31:0]       lines_issued,
  output logic [31:0]       lines_acked,
  output logic              quiesced,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  STALL_LVL = CNT_W'(FIFO_DEPTH - SKID_MARGIN);
  localparam logic [OUTS_W-1:0] OUTS_MAX  = OUTS_W'(MAX_OUTSTANDING);

  t_wr_req           push_req;
  t_wr_req           head;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  fifo_count_next;
  logic              fifo_empty;
  logic              fifo_overflow;
  logic              issue;
  logic [15:0]       mdata_cnt;

  assign push_req.addr = wr_addr;
  assign push_req.data = wr_data;
  assign issue = ~fifo_empty & ~c1_tx_almfull & (outstanding < OUTS_MAX);

  cci_wr_issuer_skid_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (wr_valid),
    .push_data  (push_req),
    .pop        (issue),
    .head       (head),
    .count      (fifo_count),
    .count_next (fifo_count_next),
    .empty      (fifo_empty),
    .overflow   (fifo_overflow)
  );

  // Issue register: request fields and tag only move when a request goes out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall       <= 1'b1;
      c1_tx_valid <= 1'b0;
      c1_tx_addr  <= '0;
      c1_tx_data  <= '0;
      c1_tx_mdata <= '0;
      mdata_cnt   <= '0;
    end else begin
      stall       <= (fifo_count_next >= STALL_LVL) | c1_tx_almfull;
      c1_tx_valid <= issue;
      if (issue) begin
        c1_tx_addr  <= head.addr;
        c1_tx_data  <= head.data;
        c1_tx_mdata <= mdata_cnt;
        mdata_cnt   <= mdata_cnt + 16'd1;
      end
    end
  end

  // A response with nothing in flight and no issue alongside it is an underflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      outstanding   <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      quiesced      <= 1'b0;
    end else begin
      case ({issue, c1_rx_wr_rsp})
        2'b10: outstanding <= outstanding + OUTS_W'(1);
        2'b01: begin
          if (outstanding == '0) err_underflow <= 1'b1;
          else                   outstanding   <= outstanding - OUTS_W'(1);
        end
        default: outstanding <= outstanding;
      endcase
      if (fifo_overflow) err_overflow <= 1'b1;
      quiesced <= fifo_empty & (outstanding == '0) & ~c1_tx_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lines_issued <= '0;
      lines_acked  <= '0;
    end else if (cnt_clear && quiesced) begin
      lines_issued <= '0;
      lines_acked  <= '0;
    end else begin
      if (issue)        lines_issued <= lines_issued + 32'd1;
      if (c1_rx_wr_rsp) lines_acked  <= lines_acked + 32'd1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^fifo_count;

endmodule

// File: tb/tb_cci_wr_issuer.sv
// Scoreboard bench for cci_wr_issuer: stimulus queues expected requests, a
// negedge monitor pops and compares each c1_tx_valid beat.
module tb_cci_wr_issuer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         wr_valid;
  logic [41:0]  wr_addr;
  logic [511:0] wr_data;
  logic         stall;
  logic         c1_tx_almfull;
  logic         c1_tx_valid;
  logic [41:0]  c1_tx_addr;
  logic [511:0] c1_tx_data;
  logic [15:0]  c1_tx_mdata;
  logic         c1_rx_wr_rsp;
  logic         cnt_clear;
  logic [6:0]   outstanding;
  logic [31:0]  lines_issued;
  logic [31:0]  lines_acked;
  logic         quiesced;
  logic         err_overflow;
  logic         err_underflow;

  typedef struct {
    logic [41:0]  addr;
    logic [511:0] data;
    logic [15:0]  mdata;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_mdata;
  int          checks    = 0;
  int          failures  = 0;
  int          tx_count  = 0;
  int          base;

  always #5 clk = ~clk;

  cci_wr_issuer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_valid      (wr_valid),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .stall         (stall),
    .c1_tx_almfull (c1_tx_almfull),
    .c1_tx_valid   (c1_tx_valid),
    .c1_tx_addr    (c1_tx_addr),
    .c1_tx_data    (c1_tx_data),
    .c1_tx_mdata   (c1_tx_mdata),
    .c1_rx_wr_rsp  (c1_rx_wr_rsp),
    .cnt_clear     (cnt_clear),
    .outstanding   (outstanding),
    .lines_issued  (lines_issued),
    .lines_acked   (lines_acked),
    .quiesced      (quiesced),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  function automatic logic [511:0] make_data(input logic [41:0] a);
    logic [31:0] w;
    w = a[31:0] ^ 32'hA5C3_0000;
    return {16{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one write for one edge; accepted writes become expected requests.
  task automatic applyStimulus(input logic [41:0] a, input bit accept);
    exp_t e;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = make_data(a);
    if (accept) begin
      e.addr  = a;
      e.data  = make_data(a);
      e.mdata = exp_mdata;
      sb.push_back(e);
      exp_mdata = exp_mdata + 16'd1;
    end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic send_rsp(input int n);
    for (int i = 0; i < n; i++) begin
      c1_rx_wr_rsp = 1'b1;
      tick();
    end
    c1_rx_wr_rsp = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_quiesced(input string name);
    int k;
    k = 0;
    while (quiesced !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    checks++;
    if (quiesced !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s: quiesced got %0b expected 1 within 200 cycles", name, quiesced);
    end
  endtask

  // Monitor: every issued beat must match the oldest expected request.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1 && c1_tx_valid === 1'b1) begin
      tx_count++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_issue: got addr %0h mdata %0h expected no request", c1_tx_addr, c1_tx_mdata);
      end else begin
        e = sb.pop_front();
        if (c1_tx_addr !== e.addr || c1_tx_mdata !== e.mdata || c1_tx_data !== e.data) begin
          failures++;
          $display("[TB] FAIL issue_beat: got addr %0h mdata %0h data %0h expected addr %0h mdata %0h data %0h",
                   c1_tx_addr, c1_tx_mdata, c1_tx_data[63:0], e.addr, e.mdata, e.data[63:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    c1_tx_almfull = 1'b0; c1_rx_wr_rsp = 1'b0; cnt_clear = 1'b0;
    exp_mdata = '0;
    idle(3);

    checkOutput("rst_stall",    64'(stall), 64'd1);
    checkOutput("rst_valid",    64'(c1_tx_valid), 64'd0);
    checkOutput("rst_quiesced", 64'(quiesced), 64'd0);
    checkOutput("rst_outs",     64'(outstanding), 64'd0);
    reset_n = 1'b1;
    tick();
    checkOutput("rel_quiesced", 64'(quiesced), 64'd1);
    checkOutput("rel_stall",    64'(stall), 64'd0);

    // Five back-to-back writes, responses ten cycles later.
    for (int i = 0; i < 5; i++) applyStimulus(42'h100 + 42'(i), 1'b1);
    idle(10);
    send_rsp(5);
    idle(2);
    checkOutput("b2b_quiesced", 64'(quiesced), 64'd1);
    checkOutput("b2b_issued",   64'(lines_issued), 64'd5);
    checkOutput("b2b_acked",    64'(lines_acked), 64'd5);
    checkOutput("b2b_txcount",  64'(tx_count), 64'd5);

    // Almost-full holds issue off; three skid pushes after stall are safe.
    c1_tx_almfull = 1'b1;
    tick();
    checkOutput("almf_stall", 64'(stall), 64'd1);
    base = tx_count;
    for (int i = 0; i < 3; i++) applyStimulus(42'h200 + 42'(i), 1'b1);
    idle(17);
    checkOutput("almf_noissue", 64'(tx_count - base), 64'd0);
    checkOutput("almf_noovf",   64'(err_overflow), 64'd0);
    c1_tx_almfull = 1'b0;
    idle(5);
    checkOutput("almf_drain", 64'(tx_count - base), 64'd3);
    checkOutput("almf_stall_off", 64'(stall), 64'd0);
    send_rsp(3);
    wait_quiesced("almf_quiesce");

    // Outstanding cap: 70 writes, responses withheld.
    base = tx_count;
    for (int i = 0; i < 70; i++) applyStimulus(42'h1000 + 42'(i), 1'b1);
    idle(10);
    checkOutput("cap_issued", 64'(tx_count - base), 64'd64);
    checkOutput("cap_outs",   64'(outstanding), 64'd64);
    checkOutput("cap_noovf",  64'(err_overflow), 64'd0);
    checkOutput("cap_stall",  64'(stall), 64'd1);
    send_rsp(1);
    idle(3);
    checkOutput("cap_one_more", 64'(tx_count - base), 64'd65);
    checkOutput("cap_outs2",    64'(outstanding), 64'd64);
    send_rsp(69);
    wait_quiesced("cap_quiesce");
    checkOutput("cap_outs0", 64'(outstanding), 64'd0);

    // Issue and response on the same edge leave outstanding unchanged.
    for (int i = 0; i < 5; i++) applyStimulus(42'h2000 + 42'(i), 1'b1);
    idle(4);
    checkOutput("same_pre", 64'(outstanding), 64'd5);
    applyStimulus(42'h2005, 1'b1);
    send_rsp(1);
    checkOutput("same_valid", 64'(c1_tx_valid), 64'd1);
    checkOutput("same_outs",  64'(outstanding), 64'd5);
    send_rsp(5);
    wait_quiesced("same_quiesce");
    checkOutput("unf_pre", 64'(err_underflow), 64'd0);
    send_rsp(1);
    idle(1);
    checkOutput("unf_flag", 64'(err_underflow), 64'd1);
    checkOutput("unf_outs", 64'(outstanding), 64'd0);

    // Clear while quiesced, then overflow with stall ignored.
    wait_quiesced("clr_pre_quiesce");
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    checkOutput("clr_issued", 64'(lines_issued), 64'd0);
    checkOutput("clr_acked",  64'(lines_acked), 64'd0);
    c1_tx_almfull = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) applyStimulus(42'h3000 + 42'(i), i < 8);
    tick();
    checkOutput("ovf_flag", 64'(err_overflow), 64'd1);
    c1_tx_almfull = 1'b0;
    idle(12);
    checkOutput("ovf_issued", 64'(lines_issued), 64'd8);
    send_rsp(8);
    wait_quiesced("ovf_quiesce");

    // Clear while busy is ignored.
    for (int i = 0; i < 2; i++) applyStimulus(42'h4000 + 42'(i), 1'b1);
    idle(3);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    checkOutput("busy_clr_issued", 64'(lines_issued), 64'd10);
    checkOutput("busy_clr_acked",  64'(lines_acked), 64'd8);
    send_rsp(2);
    wait_quiesced("busy_quiesce");
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    checkOutput("idle_clr_issued", 64'(lines_issued), 64'd0);
    checkOutput("idle_clr_acked",  64'(lines_acked), 64'd0);

    // Reset in the middle of a burst.
    for (int i = 0; i < 4; i++) applyStimulus(42'h5000 + 42'(i), 1'b1);
    reset_n = 1'b0;
    tick();
    sb.delete();
    exp_mdata = '0;
    checkOutput("mid_stall", 64'(stall), 64'd1);
    checkOutput("mid_valid", 64'(c1_tx_valid), 64'd0);
    checkOutput("mid_addr",  64'(c1_tx_addr), 64'd0);
    checkOutput("mid_mdata", 64'(c1_tx_mdata), 64'd0);
    checkOutput("mid_outs",  64'(outstanding), 64'd0);
    checkOutput("mid_issued", 64'(lines_issued), 64'd0);
    checkOutput("mid_quiesced", 64'(quiesced), 64'd0);
    checkOutput("mid_errs", 64'({err_overflow, err_underflow}), 64'd0);
    reset_n = 1'b1;
    tick();
    checkOutput("post_quiesced", 64'(quiesced), 64'd1);
    send_rsp(1);
    idle(1);
    checkOutput("late_rsp_unf", 64'(err_underflow), 64'd1);
    for (int i = 0; i < 2; i++) applyStimulus(42'h6000 + 42'(i), 1'b1);
    idle(4);
    send_rsp(2);
    wait_quiesced("final_quiesce");
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
